coproc_seq: RTL and testbench

COPROC_SEQ -- requirements
Module: coproc_seq

---
 rtl/coproc_seq.sv | 168 ++++++++++++++++
 tb/tb_coproc_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/coproc_seq.sv
// Host-side sequencer for a 4-bit ADDI coprocessor. It fetches the operand from a
// local 16x4 register file, handshakes with the coprocessor and writes the result back.
module coproc_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       host_valid,
  output logic       host_ready,
  input  logic [3:0] host_imm,
  input  logic [3:0] host_src,
  input  logic [3:0] host_dst,
  input  logic       host_abort,
  input  logic       rf_we,
  input  logic [3:0] rf_waddr,
  input  logic [3:0] rf_wdata,
  input  logic [3:0] rf_raddr,
  output logic [3:0] rf_rdata,
  output logic [3:0] cp_opcode,
  output logic [3:0] cp_mio,
  output logic [3:0] cp_bus_out,
  output logic       cp_oe_n,
  input  logic [3:0] cp_bus_in,
  input  logic       cp_done,
  input  logic       cp_carry,
  output logic       res_valid,
  output logic [3:0] res_data,
  output logic       res_carry,
  output logic       err_timeout,
  output logic       err_drop
);

  typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

  localparam logic [3:0] OP_ADDI     = 4'b0001;
  localparam logic [4:0] TIMEOUT_LAST = 5'd30;

  state_t     state_q, state_d;
  logic [3:0] imm_q, imm_d;
  logic [3:0] opnd_q, opnd_d;
  logic [3:0] dst_q, dst_d;
  logic [4:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic [3:0] res_data_q, res_data_d;
  logic       res_carry_q, res_carry_d;
  logic       err_timeout_q, err_timeout_d;
  logic       err_drop_q, err_drop_d;
  logic [3:0] cp_opcode_q, cp_opcode_d;
  logic [3:0] cp_mio_q, cp_mio_d;
  logic [3:0] cp_bus_out_q, cp_bus_out_d;
  logic       cp_oe_n_q, cp_oe_n_d;
  logic [3:0] rf_q [16];
  logic [3:0] rf_d [16];
  logic       completion;

  assign completion = (state_q == RUN) && cp_done && !done_q;

  always_comb begin
    state_d       = state_q;
    imm_d         = imm_q;
    opnd_d        = opnd_q;
    dst_d         = dst_q;
    cnt_d         = cnt_q;
    done_d        = cp_done;
    res_data_d    = res_data_q;
    res_carry_d   = res_carry_q;
    err_timeout_d = err_timeout_q;
    err_drop_d    = 1'b0;
    rf_d          = rf_q;

    case (state_q)
      IDLE: begin
        if (host_valid) begin
          imm_d         = host_imm;
          opnd_d        = rf_q[host_src];
          dst_d         = host_dst;
          err_timeout_d = 1'b0;
          cnt_d         = 5'd0;
          state_d       = RUN;
        end
      end
      RUN: begin
        // Abort beats completion, and completion on the last allowed cycle beats timeout.
        if (host_abort) begin
          state_d = IDLE;
        end else if (completion) begin
          res_data_d  = cp_bus_in;
          res_carry_d = cp_carry;
          state_d     = WB;
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_timeout_d = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      WB: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Writeback is applied after the host write so it wins an address collision.
    if (rf_we) rf_d[rf_waddr] = rf_wdata;
    if (state_q == WB) begin
      rf_d[dst_q] = res_data_q;
      err_drop_d  = rf_we && (rf_waddr == dst_q);
    end

    // Coprocessor drive is registered from the next state so it lines up with RUN.
    if (state_d == RUN) begin
      cp_opcode_d  = OP_ADDI;
      cp_mio_d     = imm_d;
      cp_bus_out_d = opnd_d;
      cp_oe_n_d    = 1'b0;
    end else begin
      cp_opcode_d  = 4'd0;
      cp_mio_d     = 4'd0;
      cp_bus_out_d = 4'd0;
      cp_oe_n_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      imm_q         <= 4'd0;
      opnd_q        <= 4'd0;
      dst_q         <= 4'd0;
      cnt_q         <= 5'd0;
      done_q        <= 1'b0;
      res_data_q    <= 4'd0;
      res_carry_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      err_drop_q    <= 1'b0;
      cp_opcode_q   <= 4'd0;
      cp_mio_q      <= 4'd0;
      cp_bus_out_q  <= 4'd0;
      cp_oe_n_q     <= 1'b1;
      for (int i = 0; i < 16; i++) rf_q[i] <= 4'd0;
    end else begin
      state_q       <= state_d;
      imm_q         <= imm_d;
      opnd_q        <= opnd_d;
      dst_q         <= dst_d;
      cnt_q         <= cnt_d;
      done_q        <= done_d;
      res_data_q    <= res_data_d;
      res_carry_q   <= res_carry_d;
      err_timeout_q <= err_timeout_d;
      err_drop_q    <= err_drop_d;
      cp_opcode_q   <= cp_opcode_d;
      cp_mio_q      <= cp_mio_d;
      cp_bus_out_q  <= cp_bus_out_d;
      cp_oe_n_q     <= cp_oe_n_d;
      for (int i = 0; i < 16; i++) rf_q[i] <= rf_d[i];
    end
  end

  assign host_ready  = (state_q == IDLE);
  assign res_valid   = (state_q == WB);
  assign rf_rdata    = rf_q[rf_raddr];
  assign cp_opcode   = cp_opcode_q;
  assign cp_mio      = cp_mio_q;
  assign cp_bus_out  = cp_bus_out_q;
  assign cp_oe_n     = cp_oe_n_q;
  assign res_data    = res_data_q;
  assign res_carry   = res_carry_q;
  assign err_timeout = err_timeout_q;
  assign err_drop    = err_drop_q;

endmodule

// File: tb/tb_coproc_seq.sv
// Directed bench for coproc_seq: table of ADDI operations plus hand-written
// sequences for timeout, abort, stale done, write collisions and async reset.
module tb_coproc_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       host_valid, host_ready, host_abort;
  logic [3:0] host_imm, host_src, host_dst;
  logic       rf_we;
  logic [3:0] rf_waddr, rf_wdata, rf_raddr, rf_rdata;
  logic [3:0] cp_opcode, cp_mio, cp_bus_out, cp_bus_in;
  logic       cp_oe_n, cp_done, cp_carry;
  logic       res_valid, res_carry, err_timeout, err_drop;
  logic [3:0] res_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  coproc_seq dut (
    .clk(clk), .rst_n(rst_n),
    .host_valid(host_valid), .host_ready(host_ready),
    .host_imm(host_imm), .host_src(host_src), .host_dst(host_dst),
    .host_abort(host_abort),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .cp_opcode(cp_opcode), .cp_mio(cp_mio), .cp_bus_out(cp_bus_out), .cp_oe_n(cp_oe_n),
    .cp_bus_in(cp_bus_in), .cp_done(cp_done), .cp_carry(cp_carry),
    .res_valid(res_valid), .res_data(res_data), .res_carry(res_carry),
    .err_timeout(err_timeout), .err_drop(err_drop)
  );

  typedef struct {
    logic [3:0] src_val;
    logic [3:0] imm;
    logic [3:0] src;
    logic [3:0] dst;
    logic [3:0] exp_data;
    logic       exp_carry;
    logic       wb_we;     // host write during the WB cycle
    logic [3:0] wb_addr;
    logic [3:0] wb_data;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [3:0] a, input logic [3:0] d);
    rf_we = 1'b1; rf_waddr = a; rf_wdata = d;
    tick();
    rf_we = 1'b0;
  endtask

  task automatic read_rf(input logic [3:0] a, output logic [3:0] d);
    rf_raddr = a;
    #1;
    d = rf_rdata;
  endtask

  task automatic accept(input logic [3:0] imm, input logic [3:0] src, input logic [3:0] dst);
    host_valid = 1'b1; host_imm = imm; host_src = src; host_dst = dst;
    tick();
    host_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [4:0] sum;
    logic [3:0] rd;
    host_write(v.src, v.src_val);
    check("ready_idle", {7'd0, host_ready}, 8'd1);
    accept(v.imm, v.src, v.dst);
    check("ready_run", {7'd0, host_ready}, 8'd0);
    check("cp_opcode", {4'd0, cp_opcode}, 8'd1);
    check("cp_oe_n_run", {7'd0, cp_oe_n}, 8'd0);
    check("cp_mio", {4'd0, cp_mio}, {4'd0, v.imm});
    check("cp_bus_out", {4'd0, cp_bus_out}, {4'd0, v.src_val});
    tick();
    tick();
    // coprocessor model: 4-bit add with carry out
    sum = {1'b0, cp_mio} + {1'b0, cp_bus_out};
    cp_bus_in = sum[3:0]; cp_carry = sum[4]; cp_done = 1'b1;
    tick();
    cp_done = 1'b0;
    check("res_valid_wb", {7'd0, res_valid}, 8'd1);
    check("res_data", {4'd0, res_data}, {4'd0, v.exp_data});
    check("res_carry", {7'd0, res_carry}, {7'd0, v.exp_carry});
    check("cp_oe_n_wb", {7'd0, cp_oe_n}, 8'd1);
    if (v.wb_we) begin
      rf_we = 1'b1; rf_waddr = v.wb_addr; rf_wdata = v.wb_data;
    end
    tick();
    rf_we = 1'b0;
    check("res_valid_after", {7'd0, res_valid}, 8'd0);
    check("err_drop", {7'd0, err_drop}, {7'd0, v.wb_we && (v.wb_addr == v.dst)});
    read_rf(v.dst, rd);
    check("rf_dst", {4'd0, rd}, {4'd0, v.exp_data});
    if (v.wb_we && v.wb_addr != v.dst) begin
      read_rf(v.wb_addr, rd);
      check("rf_host_wr", {4'd0, rd}, {4'd0, v.wb_data});
    end
    tick();
    check("err_drop_clr", {7'd0, err_drop}, 8'd0);
    check("res_hold", {4'd0, res_data}, {4'd0, v.exp_data});
  endtask

  initial begin
    logic [3:0] rd;
    vecs[0] = '{4'h5, 4'h6, 4'd3, 4'd7, 4'hB, 1'b0, 1'b0, 4'd0, 4'd0};
    vecs[1] = '{4'h2, 4'hF, 4'd2, 4'd4, 4'h1, 1'b1, 1'b0, 4'd0, 4'd0};
    vecs[2] = '{4'h8, 4'h8, 4'd1, 4'd1, 4'h0, 1'b1, 1'b0, 4'd0, 4'd0};
    vecs[3] = '{4'h7, 4'h3, 4'd5, 4'd6, 4'hA, 1'b0, 1'b0, 4'd0, 4'd0};
    vecs[4] = '{4'h0, 4'h0, 4'd0, 4'd9, 4'h0, 1'b0, 1'b0, 4'd0, 4'd0};
    vecs[5] = '{4'h5, 4'h6, 4'd3, 4'd7, 4'hB, 1'b0, 1'b1, 4'd7, 4'h9};
    vecs[6] = '{4'h5, 4'h6, 4'd3, 4'd7, 4'hB, 1'b0, 1'b1, 4'd8, 4'h9};

    rst_n = 1'b0;
    host_valid = 1'b0; host_abort = 1'b0; host_imm = 4'd0; host_src = 4'd0; host_dst = 4'd0;
    rf_we = 1'b0; rf_waddr = 4'd0; rf_wdata = 4'd0; rf_raddr = 4'd0;
    cp_bus_in = 4'd0; cp_done = 1'b0; cp_carry = 1'b0;
    #12;
    check("rst_ready", {7'd0, host_ready}, 8'd1);
    check("rst_oe_n", {7'd0, cp_oe_n}, 8'd1);
    check("rst_opcode", {4'd0, cp_opcode}, 8'd0);
    check("rst_res_valid", {7'd0, res_valid}, 8'd0);
    check("rst_rf", {4'd0, rf_rdata}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Timeout: rf[7] holds B from the table, must stay untouched.
    accept(4'h1, 4'd3, 4'd7);
    repeat (30) tick();
    check("to_still_run", {7'd0, host_ready}, 8'd0);
    check("to_no_err_yet", {7'd0, err_timeout}, 8'd0);
    tick();
    check("to_ready", {7'd0, host_ready}, 8'd1);
    check("to_err", {7'd0, err_timeout}, 8'd1);
    check("to_no_valid", {7'd0, res_valid}, 8'd0);
    read_rf(4'd7, rd);
    check("to_rf_keep", {4'd0, rd}, 8'h0B);
    tick();
    check("to_sticky", {7'd0, err_timeout}, 8'd1);

    // Next accept clears the error; abort coincides with a done rise.
    accept(4'h2, 4'd3, 4'd7);
    check("acc_clr_err", {7'd0, err_timeout}, 8'd0);
    tick();
    host_abort = 1'b1; cp_done = 1'b1; cp_bus_in = 4'h3;
    tick();
    host_abort = 1'b0;
    check("abort_ready", {7'd0, host_ready}, 8'd1);
    check("abort_no_valid", {7'd0, res_valid}, 8'd0);
    check("abort_oe_n", {7'd0, cp_oe_n}, 8'd1);
    tick();
    read_rf(4'd7, rd);
    check("abort_rf_keep", {4'd0, rd}, 8'h0B);

    // Done already high at accept must be ignored until it falls and rises.
    accept(4'h1, 4'd3, 4'd2);
    tick();
    tick();
    check("stale_done_run", {7'd0, host_ready}, 8'd0);
    cp_done = 1'b0;
    tick();
    cp_done = 1'b1; cp_bus_in = 4'h6; cp_carry = 1'b0;
    tick();
    cp_done = 1'b0;
    check("fresh_done_wb", {7'd0, res_valid}, 8'd1);
    check("fresh_done_data", {4'd0, res_data}, 8'h06);
    tick();
    read_rf(4'd2, rd);
    check("fresh_done_rf", {4'd0, rd}, 8'h06);

    // Source rewritten after accept does not alter the operand.
    accept(4'h1, 4'd3, 4'd2);
    host_write(4'd3, 4'hE);
    check("opnd_latched", {4'd0, cp_bus_out}, 8'h05);

    // Asynchronous reset in the middle of RUN.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ready", {7'd0, host_ready}, 8'd1);
    check("arst_oe_n", {7'd0, cp_oe_n}, 8'd1);
    check("arst_mio", {4'd0, cp_mio}, 8'd0);
    check("arst_res_data", {4'd0, res_data}, 8'd0);
    read_rf(4'd7, rd);
    check("arst_rf", {4'd0, rd}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("arst_ready_after", {7'd0, host_ready}, 8'd1);
    check("arst_no_valid", {7'd0, res_valid}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
